// File: rtl/bootrom_arb_pkg.sv
// ----------------------------------------------------------------------------
// bootrom_arb_pkg
// Shared types and constants for the boot ROM arbiter.
//   state_t    : arbiter FSM states (IDLE, READ, CAPTURE)
//   req_id_t   : requester identifier (REQ_CPU = 0, REQ_DBG = 1)
//   ROM_LATENCY: cycles from the enabled ROM edge until rom_data is valid
// ----------------------------------------------------------------------------
package bootrom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  localparam int ROM_LATENCY = 1;

endpackage : bootrom_arb_pkg

// File: rtl/bootrom_arb_pick.sv
// ----------------------------------------------------------------------------
// bootrom_arb_pick
// Combinational grant selection between the CPU and debug requesters.
// Build option: BOOTROM_ARB_RR_EN selects round-robin (tie goes to ptr);
// without it the CPU always wins a tie and there is no pointer input.
// Ports:
//   eligible [1:0] : bit per requester (index = req_id_t), 1 = may be granted
//   ptr            : requester favoured on a tie (round-robin build only)
//   grant          : chosen requester; meaningful only when eligible != 0
// ----------------------------------------------------------------------------
module bootrom_arb_pick
  import bootrom_arb_pkg::*;
(
  input  logic [1:0] eligible,
`ifdef BOOTROM_ARB_RR_EN
  input  req_id_t    ptr,
`endif
  output req_id_t    grant
);

`ifdef BOOTROM_ARB_RR_EN
  always_comb begin
    if (eligible == 2'b11) begin
      grant = ptr;
    end else if (eligible[REQ_DBG]) begin
      grant = REQ_DBG;
    end else begin
      grant = REQ_CPU;
    end
  end
`else
  always_comb begin
    grant = (!eligible[REQ_CPU] && eligible[REQ_DBG]) ? REQ_DBG : REQ_CPU;
  end
`endif

endmodule : bootrom_arb_pick

// File: rtl/bootrom_arbiter.sv
// ----------------------------------------------------------------------------
// bootrom_arbiter
// Shares one synchronous 16-bit boot ROM between a CPU and a debug/loader
// requester. An access takes IDLE -> READ -> CAPTURE; the ack (or berr) is a
// registered one-cycle pulse when CAPTURE completes. Out-of-window addresses
// never reach the ROM and get a berr one cycle after the grant.
// Build option: BOOTROM_ARB_RR_EN enables round-robin arbitration (default:
// fixed priority, CPU wins ties).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cpu_req/addr/data/ack/berr : CPU read port
//   dbg_req/addr/data/ack/berr : debug/loader read port
//   rom_addr, rom_enable       : ROM address (bit 0 clear) and clock enable
//   rom_data, rom_berr         : ROM read data and error, sampled in CAPTURE
//   busy                       : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module bootrom_arbiter
  import bootrom_arb_pkg::*;
#(
  parameter int          ROM_ADDR_BITS = 11,
  parameter logic [31:0] ROM_BASE      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [15:0] cpu_data,
  output logic        cpu_ack,
  output logic        cpu_berr,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic [15:0] dbg_data,
  output logic        dbg_ack,
  output logic        dbg_berr,
  output logic [31:0] rom_addr,
  output logic        rom_enable,
  input  logic [15:0] rom_data,
  input  logic        rom_berr,
  output logic        busy
);

  state_t      state_q, state_d;
  req_id_t     grant_q;
  req_id_t     pick_id;
  req_id_t     oob_id_q;
  logic        oob_pend_q;
  logic [1:0]  done_q;
  logic [1:0]  req_vec;
  logic [1:0]  eligible;
  logic [1:0]  ack_set, berr_set;
  logic [1:0]  ack_q, berr_q;
  logic [31:0] sel_addr;
  logic        sel_in_win;
  logic        grant_now;
  logic [31:0] rom_addr_q;
  logic [15:0] cpu_data_q, dbg_data_q;

  function automatic logic in_window(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - ROM_BASE;
    return (addr >= ROM_BASE) && ((offset >> ROM_ADDR_BITS) == 32'd0);
  endfunction

  assign req_vec = {dbg_req, cpu_req};

  // A requester with an out-of-window berr still in flight is held off so the
  // same request is not granted twice before its done flag can be set.
  always_comb begin
    eligible = req_vec & ~done_q;
    if (oob_pend_q) begin
      eligible[oob_id_q] = 1'b0;
    end
  end

`ifdef BOOTROM_ARB_RR_EN
  req_id_t ptr_q;

  bootrom_arb_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (pick_id)
  );

  // The pointer only moves on a contested grant, so an uncontested grant does
  // not steal the other requester's turn at the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_CPU;
    end else if (state_q == IDLE && eligible == 2'b11) begin
      ptr_q <= (pick_id == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end
  end
`else
  bootrom_arb_pick u_pick (
    .eligible (eligible),
    .grant    (pick_id)
  );
`endif

  assign grant_now  = (state_q == IDLE) && (eligible != 2'b00);
  assign sel_addr   = (pick_id == REQ_DBG) ? dbg_addr : cpu_addr;
  assign sel_in_win = in_window(sel_addr);

  // ---------------------------------------------------------------- FSM ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_now && sel_in_win) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_enable = (state_q == READ);
    busy       = (state_q != IDLE);
  end

  // ------------------------------------------------------ completion -------
  // Pulses go only to a requester still asserting req; a withdrawn request
  // finishes silently.
  always_comb begin
    ack_set  = 2'b00;
    berr_set = 2'b00;
    if (oob_pend_q && req_vec[oob_id_q]) begin
      berr_set[oob_id_q] = 1'b1;
    end
    if (state_q == CAPTURE && req_vec[grant_q]) begin
      if (rom_berr) begin
        berr_set[grant_q] = 1'b1;
      end else begin
        ack_set[grant_q] = 1'b1;
      end
    end
  end

  // NOTE: the two data registers are ordinary flops, not a memory, so they
  // take the asynchronous reset like every other piece of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= REQ_CPU;
      oob_pend_q <= 1'b0;
      oob_id_q   <= REQ_CPU;
      rom_addr_q <= 32'h0;
      done_q     <= 2'b00;
      ack_q      <= 2'b00;
      berr_q     <= 2'b00;
      cpu_data_q <= 16'h0000;
      dbg_data_q <= 16'h0000;
    end else begin
      oob_pend_q <= 1'b0;
      if (grant_now) begin
        grant_q    <= pick_id;
        rom_addr_q <= sel_addr & ~32'h1;
        if (!sel_in_win) begin
          oob_pend_q <= 1'b1;
          oob_id_q   <= pick_id;
        end
      end

      if (state_q == CAPTURE && !rom_berr) begin
        if (grant_q == REQ_DBG) begin
          dbg_data_q <= rom_data;
        end else begin
          cpu_data_q <= rom_data;
        end
      end

      ack_q  <= ack_set;
      berr_q <= berr_set;
      // Done holds from the completion pulse until req is seen low.
      done_q <= req_vec & (done_q | ack_set | berr_set);
    end
  end

  assign rom_addr = rom_addr_q;
  assign cpu_data = cpu_data_q;
  assign dbg_data = dbg_data_q;
  assign cpu_ack  = ack_q[REQ_CPU];
  assign dbg_ack  = ack_q[REQ_DBG];
  assign cpu_berr = berr_q[REQ_CPU];
  assign dbg_berr = berr_q[REQ_DBG];

endmodule : bootrom_arbiter

// File: tb/tb_bootrom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bootrom_arbiter
// Directed bench for bootrom_arbiter with a one-cycle-latency ROM model.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected arbitration order follows BOOTROM_ARB_RR_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bootrom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, dbg_req;
  logic [31:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_data, dbg_data;
  logic        cpu_ack, cpu_berr, dbg_ack, dbg_berr;
  logic [31:0] rom_addr;
  logic        rom_enable;
  logic [15:0] rom_data;
  logic        rom_berr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bootrom_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .cpu_berr   (cpu_berr),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ack    (dbg_ack),
    .dbg_berr   (dbg_berr),
    .rom_addr   (rom_addr),
    .rom_enable (rom_enable),
    .rom_data   (rom_data),
    .rom_berr   (rom_berr),
    .busy       (busy)
  );

  // ROM contents used by the scenarios.
  function automatic logic [15:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 16'h4EFA;
      32'h0000_0010: return 16'h1111;
      32'h0000_0020: return 16'h2222;
      default:       return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rom_enable) rom_data <= rom_word(rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ack_cnt;

  initial begin
    rst_n    = 1'b0;
    cpu_req  = 1'b0;
    dbg_req  = 1'b0;
    cpu_addr = 32'h0;
    dbg_addr = 32'h0;
    rom_data = 16'h0;
    rom_berr = 1'b0;
    tick();
    tick();
    check("rst_busy",   busy,       1'b0);
    check("rst_romen",  rom_enable, 1'b0);
    check("rst_romadr", rom_addr,   32'h0);
    check("rst_cdata",  cpu_data,   16'h0);
    check("rst_ack",    {cpu_ack, cpu_berr, dbg_ack, dbg_berr}, 4'b0);
    rst_n = 1'b1;
    tick();

    // CPU read of 0x8.
    cpu_addr = 32'h0000_0008;
    cpu_req  = 1'b1;
    tick();                                   // edge N
    check("rd_romen1",  rom_enable, 1'b1);
    check("rd_busy1",   busy,       1'b1);
    check("rd_romadr",  rom_addr,   32'h8);
    check("rd_ack_n",   cpu_ack,    1'b0);
    tick();                                   // edge N+1
    check("rd_romen2",  rom_enable, 1'b0);
    check("rd_busy2",   busy,       1'b1);
    check("rd_ack_n1",  cpu_ack,    1'b0);
    tick();                                   // edge N+2
    check("rd_ack",     cpu_ack,    1'b1);
    check("rd_data",    cpu_data,   16'h4EFA);
    check("rd_busy3",   busy,       1'b0);

    // Held request: 10 cycles total, only one ack.
    ack_cnt = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (cpu_ack) ack_cnt++;
    end
    check("hold_once",  ack_cnt,    1);
    cpu_req = 1'b0;
    tick();
    check("hold_low",   cpu_ack,    1'b0);
    cpu_req = 1'b1;
    tick();
    tick();
    tick();
    check("hold_again", cpu_ack,    1'b1);
    tick();
    check("hold_pulse", cpu_ack,    1'b0);
    cpu_req = 1'b0;
    tick();
    check("hold_kept",  cpu_data,   16'h4EFA);

    // Simultaneous requests.
    cpu_addr = 32'h0000_0010;
    dbg_addr = 32'h0000_0020;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    tick();                                   // M
    check("arb1_adr",   rom_addr,   32'h10);
    tick();
    tick();                                   // M+2
    check("arb1_cack",  {cpu_ack, dbg_ack}, 2'b10);
    check("arb1_cdat",  cpu_data,   16'h1111);
    tick();                                   // M+3: second grant
    check("arb2_adr",   rom_addr,   32'h20);
    tick();
    tick();                                   // M+5
    check("arb2_dack",  {cpu_ack, dbg_ack}, 2'b01);
    check("arb2_ddat",  dbg_data,   16'h2222);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    tick();
`ifdef BOOTROM_ARB_RR_EN
    check("arb3_adr",   rom_addr,   32'h20);
    tick();
    tick();
    check("arb3_ack",   {cpu_ack, dbg_ack}, 2'b01);
`else
    check("arb3_adr",   rom_addr,   32'h10);
    tick();
    tick();
    check("arb3_ack",   {cpu_ack, dbg_ack}, 2'b10);
`endif
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();

    // Out-of-window debug access (first address past the window).
    dbg_addr = 32'h0000_0800;
    dbg_req  = 1'b1;
    tick();                                   // N
    check("oob_romen0", rom_enable, 1'b0);
    check("oob_busy",   busy,       1'b0);
    check("oob_berr0",  dbg_berr,   1'b0);
    tick();                                   // N+1
    check("oob_berr1",  {dbg_berr, dbg_ack, rom_enable}, 3'b100);
    tick();                                   // N+2
    check("oob_berr2",  {dbg_berr, rom_enable}, 2'b00);
    check("oob_ddat",   dbg_data,   16'h2222);
    dbg_req = 1'b0;
    tick();

    // Last word inside the window.
    dbg_addr = 32'h0000_07FE;
    dbg_req  = 1'b1;
    tick();
    check("edge_romen", rom_enable, 1'b1);
    tick();
    tick();
    check("edge_ack",   {dbg_ack, dbg_berr}, 2'b10);
    check("edge_data",  dbg_data,   16'hDEAD);
    dbg_req = 1'b0;
    tick();

    // Request withdrawn before CAPTURE: no ack, data still written.
    dbg_addr = 32'h0000_0020;
    dbg_req  = 1'b1;
    tick();
    dbg_req  = 1'b0;
    tick();
    tick();
    check("wd_ack",     {dbg_ack, dbg_berr}, 2'b00);
    check("wd_data",    dbg_data,   16'h2222);
    tick();

    // Reset asserted during READ; odd address has bit 0 dropped.
    cpu_addr = 32'h0000_0009;
    cpu_req  = 1'b1;
    tick();
    check("rr_adr",     rom_addr,   32'h8);
    check("rr_romen",   rom_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rr_outs",    {rom_enable, busy, cpu_ack, cpu_berr, dbg_ack, dbg_berr}, 6'b0);
    check("rr_romadr",  rom_addr,   32'h0);
    check("rr_data",    {cpu_data, dbg_data}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();                                   // first sampling edge
    check("rr_busy",    busy,       1'b1);
    tick();
    tick();
    check("rr_ack",     cpu_ack,    1'b1);
    check("rr_cdat",    cpu_data,   16'h4EFA);
    cpu_req = 1'b0;
    tick();

    // ROM error during CAPTURE.
    cpu_addr = 32'h0000_0010;
    cpu_req  = 1'b1;
    tick();                                   // READ
    tick();                                   // CAPTURE
    rom_berr = 1'b1;
    tick();
    rom_berr = 1'b0;
    check("rb_pulse",   {cpu_berr, cpu_ack}, 2'b10);
    check("rb_data",    cpu_data,   16'h4EFA);
    tick();
    check("rb_once",    cpu_berr,   1'b0);
    cpu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bootrom_arbiter
